// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared constants and helpers for the byte-serial memory controller:
//   load/store func3 encodings, RAM bus widths and the access-size decode.
package mem_ctrl_pkg;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;
  localparam logic [2:0] FUNC3_SB  = 3'b000;
  localparam logic [2:0] FUNC3_SH  = 3'b001;

  // Width of the RAM data bus and default RAM address bus.
  localparam int MEM_DATA_W = 8;
  localparam int RAM_ADDR_W = 32;

  // Number of bytes moved by an access; only func3[1:0] matters,
  // and any 1x code is a full word.
  function automatic logic [2:0] access_bytes(input logic [2:0] func3);
    logic [2:0] n;
    case (func3[1:0])
      FUNC3_SB[1:0]: n = 3'd1;
      FUNC3_SH[1:0]: n = 3'd2;
      default:       n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext
//   Combinational load-data extension. Takes the little-endian assembled
//   32-bit raw word and the load func3 and returns the sign- or
//   zero-extended result. Word (and any unlisted) codes pass through.
//   Ports:
//     i_raw   [31:0]  assembled bytes, lane 0 = lowest address
//     i_func3 [2:0]   load size/sign code
//     o_data  [31:0]  extended load data
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_func3)
      FUNC3_LB:  o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      FUNC3_LBU: o_data = {24'd0, i_raw[7:0]};
      FUNC3_LH:  o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      FUNC3_LHU: o_data = {16'd0, i_raw[15:0]};
      default:   o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Byte-serial memory access controller. Serialises data loads/stores
//   (from stage_mem) and instruction fetches (from IF) onto one 8-bit
//   synchronous RAM port whose read data lags its address by one cycle.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     mem_req_i/we/func3/addr/wdata  data access request (held until done)
//     mem_done_o, mem_rdata_o  data completion pulse and extended load data
//     if_req_i, if_addr_i      fetch request (held until done)
//     if_done_o, if_inst_o     fetch completion pulse and fetched word
//     stall_req_o              pipeline freeze while a data access is pending
//     ram_addr_o/wr_o/dout_o   RAM address, write enable, write data
//     ram_din_i                RAM read data for the previous cycle's address
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W  // must not exceed 32
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [2:0]            mem_func3_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  output logic                  if_done_o,
  output logic [31:0]           if_inst_o,
  output logic                  stall_req_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic                  ram_wr_o,
  output logic [MEM_DATA_W-1:0] ram_dout_o,
  input  logic [MEM_DATA_W-1:0] ram_din_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [2:0]        r_cnt, r_n, r_func3;
  logic              r_is_fetch;
  logic [31:0]       r_base, r_wdata, r_raw, r_rdata, r_inst;
  logic [ADDR_W-1:0] r_ram_addr;

  logic              w_acc_mem, w_acc_if;
  logic [31:0]       w_acc_addr, w_addr_next, w_raw_next, w_ext;
  logic [2:0]        w_cnt_inc;
  logic [1:0]        w_lane;

  assign w_acc_mem   = (r_state == ST_IDLE) & mem_req_i;
  assign w_acc_if    = (r_state == ST_IDLE) & ~mem_req_i & if_req_i;
  assign w_acc_addr  = w_acc_mem ? mem_addr_i : if_addr_i;
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_addr_next = r_base + {29'd0, w_cnt_inc};
  // Read data arriving now belongs to the address issued last cycle,
  // i.e. byte lane cnt-1 (cnt=4 wraps to lane 3).
  assign w_lane      = r_cnt[1:0] - 2'd1;

  always_comb begin
    w_raw_next = r_raw;
    w_raw_next[{w_lane, 3'b000} +: 8] = ram_din_i;
  end

  mem_load_ext u_load_ext (
    .i_raw   (w_raw_next),
    .i_func3 (r_func3),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i)     w_state_next = mem_we_i ? ST_WR : ST_RD;
        else if (if_req_i) w_state_next = ST_RD;
      end
      // RD runs one extra count to collect the last lagging byte.
      ST_RD:   if (r_cnt == r_n)        w_state_next = ST_DONE;
      ST_WR:   if (r_cnt == r_n - 3'd1) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Control and output-visible registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_is_fetch <= 1'b0;
      r_ram_addr <= '0;
      r_rdata    <= '0;
      r_inst     <= '0;
    end else begin
      if (w_acc_mem | w_acc_if) begin
        r_cnt      <= '0;
        r_is_fetch <= w_acc_if;
        r_ram_addr <= w_acc_addr[ADDR_W-1:0];
      end else if (r_state == ST_RD || r_state == ST_WR) begin
        r_cnt <= w_cnt_inc;
        // Address is registered one count ahead; it freezes on the last byte.
        if (w_cnt_inc < r_n) r_ram_addr <= w_addr_next[ADDR_W-1:0];
      end
      if (r_state == ST_RD && r_cnt == r_n) begin
        if (r_is_fetch) r_inst  <= w_raw_next;
        else            r_rdata <= w_ext;
      end
    end
  end

  // Per-transaction data, meaningful only between accept and DONE.
  always_ff @(posedge clk) begin
    if (w_acc_mem | w_acc_if) begin
      r_base  <= w_acc_addr;
      r_n     <= w_acc_mem ? access_bytes(mem_func3_i) : 3'd4;
      r_func3 <= w_acc_mem ? mem_func3_i : FUNC3_LW;
      r_wdata <= mem_wdata_i;
      r_raw   <= '0;
    end else if (r_state == ST_RD && r_cnt != 3'd0) begin
      r_raw <= w_raw_next;
    end
  end

  // rst gates the strobes in the cycle it is asserted so an abort
  // takes effect before the next RAM edge.
  assign ram_wr_o    = (r_state == ST_WR) & ~rst;
  assign ram_dout_o  = (r_state == ST_WR) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : '0;
  assign ram_addr_o  = r_ram_addr;
  assign mem_done_o  = (r_state == ST_DONE) & ~r_is_fetch & ~rst;
  assign if_done_o   = (r_state == ST_DONE) &  r_is_fetch & ~rst;
  assign mem_rdata_o = r_rdata;
  assign if_inst_o   = r_inst;
  assign stall_req_o = mem_req_i & ~mem_done_o;

endmodule
